axi4_burst_addr_gen: RTL and testbench

Parametrised AXI4 burst address sequencer. Accepts one AW/AR-style command (`id`, `addr`, `len`, `size`, `burst`) and expands it into one per-beat record: beat address, byte-lane offset, beat index, last flag and a protocol-error flag. It sits at the front of every AXI4 slave and interconnect endpoint and replaces per-slave address arithmetic. It uses the `axi4` package encodings for `axi4_len_t`, `axi4_size_t` and `axi4_burst_t`.

---
 rtl/axi4_burst_addr_gen.sv | 177 +++++++++++++++++
 tb/tb_axi4_burst_addr_gen.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_burst_addr_gen.sv
// AXI4 burst address sequencer: expands one AW/AR-style command into a registered
// stream of per-beat records (address, lane offset, index, last, error).
module axi4_burst_addr_gen #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ID_WIDTH   = 4,
  localparam int unsigned DATA_BYTES = DATA_WIDTH / 8,
  localparam int unsigned LANE_W     = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ID_WIDTH-1:0]   cmd_id,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  input  logic [2:0]            cmd_size,
  input  logic [1:0]            cmd_burst,
  output logic                  beat_valid,
  input  logic                  beat_ready,
  output logic [ID_WIDTH-1:0]   beat_id,
  output logic [ADDR_WIDTH-1:0] beat_addr,
  output logic [LANE_W-1:0]     beat_offset,
  output logic [7:0]            beat_index,
  output logic                  beat_last,
  output logic                  beat_error
);

  // axi4_burst_t encodings
  localparam logic [1:0] BurstFixed = 2'b00;
  localparam logic [1:0] BurstIncr  = 2'b01;
  localparam logic [1:0] BurstWrap  = 2'b10;

  localparam logic [2:0]            SizeMax = 3'($clog2(DATA_BYTES));
  localparam logic [ADDR_WIDTH-1:0] AddrOne = ADDR_WIDTH'(1);

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  state_e state_q, state_d;

  logic                  cmd_hs, beat_hs;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            index_q, index_d;
  logic                  last_q, last_d;
  logic                  error_q, error_d;
  logic [7:0]            len_q, len_d;
  logic [ADDR_WIDTH-1:0] bytes_q, bytes_d;
  logic                  hold_q, hold_d;  // address never moves (FIXED or error burst)
  logic                  wrap_q, wrap_d;
  logic [ADDR_WIDTH-1:0] wrap_lo_q, wrap_lo_d;
  logic [ADDR_WIDTH-1:0] wrap_hi_q, wrap_hi_d;

  logic [ADDR_WIDTH-1:0] cmd_bytes, cmd_mask, cmd_total, cmd_wrap_lo;
  logic [16:0]           cmd_total_x;  // full burst byte count, up to 256 * 128
  logic [11:0]           cmd_aligned_lo;
  logic                  cmd_cross4k, cmd_err;
  logic [ADDR_WIDTH-1:0] next_addr, incr_addr;

  // Command decode: burst geometry and legality, evaluated on the raw command inputs
  always_comb begin
    cmd_bytes      = AddrOne << cmd_size;
    cmd_mask       = ~(cmd_bytes - AddrOne);
    cmd_total_x    = ({9'd0, cmd_len} + 17'd1) << cmd_size;
    cmd_total      = ADDR_WIDTH'(cmd_total_x);
    cmd_wrap_lo    = cmd_addr & ~(cmd_total - AddrOne);
    cmd_aligned_lo = cmd_addr[11:0] & cmd_mask[11:0];
    cmd_cross4k    = ({5'd0, cmd_aligned_lo} + cmd_total_x) > 17'd4096;

    cmd_err = (cmd_size > SizeMax);
    case (cmd_burst)
      BurstFixed: if (cmd_len > 8'd15) cmd_err = 1'b1;
      BurstIncr:  if (cmd_cross4k) cmd_err = 1'b1;
      BurstWrap: begin
        if (!(cmd_len == 8'd1 || cmd_len == 8'd3 || cmd_len == 8'd7 || cmd_len == 8'd15)) begin
          cmd_err = 1'b1;
        end
        if ((cmd_addr & ~cmd_mask) != '0) cmd_err = 1'b1;
      end
      default:    cmd_err = 1'b1;
    endcase
  end

  // Output decode: beat_valid is the state, cmd_ready also opens on the last-beat handshake
  always_comb begin
    beat_valid = (state_q == StBurst);
    cmd_ready  = !rst && ((state_q == StIdle) || (beat_valid && beat_ready && last_q));
  end

  assign cmd_hs  = cmd_valid && cmd_ready;
  assign beat_hs = beat_valid && beat_ready;

  // Next-state: a last-beat handshake without a chained command returns to idle
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (cmd_hs) state_d = StBurst;
      StBurst: if (beat_hs && last_q && !cmd_hs) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Beat datapath: load beat 0 on acceptance, otherwise advance on a non-last handshake
  always_comb begin
    incr_addr = (addr_q & ~(bytes_q - AddrOne)) + bytes_q;
    next_addr = (wrap_q && (incr_addr == wrap_hi_q)) ? wrap_lo_q : incr_addr;

    id_d      = id_q;
    addr_d    = addr_q;
    index_d   = index_q;
    last_d    = last_q;
    error_d   = error_q;
    len_d     = len_q;
    bytes_d   = bytes_q;
    hold_d    = hold_q;
    wrap_d    = wrap_q;
    wrap_lo_d = wrap_lo_q;
    wrap_hi_d = wrap_hi_q;

    if (cmd_hs) begin
      id_d      = cmd_id;
      addr_d    = cmd_addr;
      index_d   = 8'd0;
      last_d    = (cmd_len == 8'd0);
      error_d   = cmd_err;
      len_d     = cmd_len;
      bytes_d   = cmd_bytes;
      hold_d    = cmd_err || (cmd_burst == BurstFixed);
      wrap_d    = (cmd_burst == BurstWrap);
      wrap_lo_d = cmd_wrap_lo;
      wrap_hi_d = cmd_wrap_lo + cmd_total;
    end else if (beat_hs && !last_q) begin
      index_d = index_q + 8'd1;
      last_d  = ((index_q + 8'd1) == len_q);
      if (!hold_q) addr_d = next_addr;
    end
  end

  // State and beat registers, synchronous reset clears everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      id_q      <= '0;
      addr_q    <= '0;
      index_q   <= '0;
      last_q    <= 1'b0;
      error_q   <= 1'b0;
      len_q     <= '0;
      bytes_q   <= '0;
      hold_q    <= 1'b0;
      wrap_q    <= 1'b0;
      wrap_lo_q <= '0;
      wrap_hi_q <= '0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      index_q   <= index_d;
      last_q    <= last_d;
      error_q   <= error_d;
      len_q     <= len_d;
      bytes_q   <= bytes_d;
      hold_q    <= hold_d;
      wrap_q    <= wrap_d;
      wrap_lo_q <= wrap_lo_d;
      wrap_hi_q <= wrap_hi_d;
    end
  end

  assign beat_id     = id_q;
  assign beat_addr   = addr_q;
  assign beat_offset = addr_q[LANE_W-1:0];
  assign beat_index  = index_q;
  assign beat_last   = last_q;
  assign beat_error  = error_q;

endmodule

// File: tb/tb_axi4_burst_addr_gen.sv
// Directed bench for axi4_burst_addr_gen on a 64-bit bus.
module tb_axi4_burst_addr_gen;

  localparam int AW = 32;
  localparam int DW = 64;
  localparam int IW = 4;
  localparam int LW = 3;

  logic          clk, rst;
  logic          cmd_valid, cmd_ready;
  logic [IW-1:0] cmd_id;
  logic [AW-1:0] cmd_addr;
  logic [7:0]    cmd_len;
  logic [2:0]    cmd_size;
  logic [1:0]    cmd_burst;
  logic          beat_valid, beat_ready;
  logic [IW-1:0] beat_id;
  logic [AW-1:0] beat_addr;
  logic [LW-1:0] beat_offset;
  logic [7:0]    beat_index;
  logic          beat_last, beat_error;

  axi4_burst_addr_gen #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .ID_WIDTH  (IW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_id     (cmd_id),
    .cmd_addr   (cmd_addr),
    .cmd_len    (cmd_len),
    .cmd_size   (cmd_size),
    .cmd_burst  (cmd_burst),
    .beat_valid (beat_valid),
    .beat_ready (beat_ready),
    .beat_id    (beat_id),
    .beat_addr  (beat_addr),
    .beat_offset(beat_offset),
    .beat_index (beat_index),
    .beat_last  (beat_last),
    .beat_error (beat_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic          start;
    logic [1:0]    burst;
    logic [AW-1:0] addr;
    logic [7:0]    len;
    logic [2:0]    size;
    logic [IW-1:0] id;
    logic [AW-1:0] e_addr;
    logic [LW-1:0] e_off;
    logic [7:0]    e_idx;
    logic          e_last;
    logic          e_err;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] beat_vec();
    return {14'd0, beat_valid, beat_id, beat_addr, beat_offset, beat_index, beat_last, beat_error};
  endfunction

  function automatic logic [63:0] exp_vec(input logic [IW-1:0] id, input logic [AW-1:0] a,
                                          input logic [LW-1:0] o, input logic [7:0] i,
                                          input logic l, input logic e);
    return {14'd0, 1'b1, id, a, o, i, l, e};
  endfunction

  task automatic add(input logic st, input logic [1:0] b, input logic [AW-1:0] a,
                     input logic [7:0] l, input logic [2:0] s, input logic [IW-1:0] id,
                     input logic [AW-1:0] ea, input logic [LW-1:0] eo, input logic [7:0] ei,
                     input logic el, input logic ee);
    vec_t v;
    v.start = st; v.burst = b; v.addr = a; v.len = l; v.size = s; v.id = id;
    v.e_addr = ea; v.e_off = eo; v.e_idx = ei; v.e_last = el; v.e_err = ee;
    vecs.push_back(v);
  endtask

  // Present a command from idle and hold it until accepted.
  task automatic issue_cmd(input logic [1:0] b, input logic [AW-1:0] a, input logic [7:0] l,
                           input logic [2:0] s, input logic [IW-1:0] id);
    int g;
    @(negedge clk);
    cmd_burst = b; cmd_addr = a; cmd_len = l; cmd_size = s; cmd_id = id;
    cmd_valid = 1'b1;
    #1;
    g = 0;
    while (!cmd_ready && g < 20) begin
      @(posedge clk);
      #1;
      g++;
    end
    check("cmd_accept", cmd_ready, 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_addr  = '1;  // scribble: fields must only matter on the handshake
    cmd_len   = 8'hFF;
  endtask

  // Consume one beat with beat_ready high and compare it.
  task automatic step(input string name, input logic [63:0] exp);
    @(negedge clk);
    beat_ready = 1'b1;
    #1;
    check(name, beat_vec(), exp);
    @(posedge clk);
    #1;
    beat_ready = 1'b0;
  endtask

  logic [1:0]    cb[3];
  logic [AW-1:0] ca[3];
  logic [7:0]    cl[3];
  logic [2:0]    cs[3];
  logic [IW-1:0] cid[3];
  logic [AW-1:0] bea[10];
  logic [7:0]    bei[10];
  logic          bel[10];
  logic [IW-1:0] beid[10];
  logic          bh, ch, stalled, bubble_chk;
  logic [63:0]   prev;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ci, k, cyc;
    rst = 1'b1; cmd_valid = 1'b0; beat_ready = 1'b0;
    cmd_id = '0; cmd_addr = '0; cmd_len = '0; cmd_size = '0; cmd_burst = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_beat_zero", beat_vec(), 64'd0);
    rst = 1'b0;
    #1;
    check("post_rst_cmd_ready", cmd_ready, 1);

    // Directed vector table: one entry per expected beat.
    add(1, 2'd1, 32'h1002, 8'd3, 3'd2, 4'd1, 32'h1002, 3'd2, 8'd0, 0, 0);
    add(0, 2'd0, 32'h0,    8'd0, 3'd0, 4'd1, 32'h1004, 3'd4, 8'd1, 0, 0);
    add(0, 2'd0, 32'h0,    8'd0, 3'd0, 4'd1, 32'h1008, 3'd0, 8'd2, 0, 0);
    add(0, 2'd0, 32'h0,    8'd0, 3'd0, 4'd1, 32'h100C, 3'd4, 8'd3, 1, 0);
    add(1, 2'd2, 32'h38,   8'd3, 3'd3, 4'd2, 32'h38,   3'd0, 8'd0, 0, 0);
    add(0, 2'd0, 32'h0,    8'd0, 3'd0, 4'd2, 32'h20,   3'd0, 8'd1, 0, 0);
    add(0, 2'd0, 32'h0,    8'd0, 3'd0, 4'd2, 32'h28,   3'd0, 8'd2, 0, 0);
    add(0, 2'd0, 32'h0,    8'd0, 3'd0, 4'd2, 32'h30,   3'd0, 8'd3, 1, 0);
    add(1, 2'd0, 32'h44,   8'd2, 3'd2, 4'd3, 32'h44,   3'd4, 8'd0, 0, 0);
    add(0, 2'd0, 32'h0,    8'd0, 3'd0, 4'd3, 32'h44,   3'd4, 8'd1, 0, 0);
    add(0, 2'd0, 32'h0,    8'd0, 3'd0, 4'd3, 32'h44,   3'd4, 8'd2, 1, 0);
    add(1, 2'd1, 32'hFF8,  8'd1, 3'd3, 4'd4, 32'hFF8,  3'd0, 8'd0, 0, 1);
    add(0, 2'd0, 32'h0,    8'd0, 3'd0, 4'd4, 32'hFF8,  3'd0, 8'd1, 1, 1);
    add(1, 2'd2, 32'h40,   8'd2, 3'd2, 4'd5, 32'h40,   3'd0, 8'd0, 0, 1);
    add(0, 2'd0, 32'h0,    8'd0, 3'd0, 4'd5, 32'h40,   3'd0, 8'd1, 0, 1);
    add(0, 2'd0, 32'h0,    8'd0, 3'd0, 4'd5, 32'h40,   3'd0, 8'd2, 1, 1);
    add(1, 2'd1, 32'h100,  8'd1, 3'd4, 4'd6, 32'h100,  3'd0, 8'd0, 0, 1);
    add(0, 2'd0, 32'h0,    8'd0, 3'd0, 4'd6, 32'h100,  3'd0, 8'd1, 1, 1);
    add(1, 2'd3, 32'h200,  8'd0, 3'd0, 4'd7, 32'h200,  3'd0, 8'd0, 1, 1);
    add(1, 2'd1, 32'h7,    8'd0, 3'd0, 4'd8, 32'h7,    3'd7, 8'd0, 1, 0);
    add(1, 2'd2, 32'h3,    8'd1, 3'd2, 4'd9, 32'h3,    3'd3, 8'd0, 0, 1);
    add(0, 2'd0, 32'h0,    8'd0, 3'd0, 4'd9, 32'h3,    3'd3, 8'd1, 1, 1);
    add(1, 2'd2, 32'hC,    8'd1, 3'd2, 4'hA, 32'hC,    3'd4, 8'd0, 0, 0);
    add(0, 2'd0, 32'h0,    8'd0, 3'd0, 4'hA, 32'h8,    3'd0, 8'd1, 1, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].start) issue_cmd(vecs[i].burst, vecs[i].addr, vecs[i].len, vecs[i].size,
                                   vecs[i].id);
      step($sformatf("vec%0d", i), exp_vec(vecs[i].id, vecs[i].e_addr, vecs[i].e_off,
                                           vecs[i].e_idx, vecs[i].e_last, vecs[i].e_err));
    end

    // FIXED with len 16: illegal, but all 17 beats still come out
    issue_cmd(2'd0, 32'h44, 8'd16, 3'd2, 4'hB);
    for (int i = 0; i <= 16; i++) begin
      step($sformatf("fixed17_beat%0d", i),
           exp_vec(4'hB, 32'h44, 3'd4, 8'(i), (i == 16), 1'b1));
    end
    @(negedge clk);
    #1;
    check("fixed17_done", beat_valid, 0);

    // Back-to-back bursts with random stalls
    cb[0] = 2'd1; ca[0] = 32'h100;  cl[0] = 8'd3; cs[0] = 3'd3; cid[0] = 4'h1;
    cb[1] = 2'd1; ca[1] = 32'h2000; cl[1] = 8'd1; cs[1] = 3'd2; cid[1] = 4'h2;
    cb[2] = 2'd2; ca[2] = 32'h38;   cl[2] = 8'd3; cs[2] = 3'd3; cid[2] = 4'h3;
    bea[0] = 32'h100;  bea[1] = 32'h108;  bea[2] = 32'h110; bea[3] = 32'h118;
    bea[4] = 32'h2000; bea[5] = 32'h2004;
    bea[6] = 32'h38;   bea[7] = 32'h20;   bea[8] = 32'h28;  bea[9] = 32'h30;
    bei[0] = 0; bei[1] = 1; bei[2] = 2; bei[3] = 3; bei[4] = 0; bei[5] = 1;
    bei[6] = 0; bei[7] = 1; bei[8] = 2; bei[9] = 3;
    for (int i = 0; i < 10; i++) begin
      bel[i]  = (i == 3 || i == 5 || i == 9);
      beid[i] = (i < 4) ? 4'h1 : ((i < 6) ? 4'h2 : 4'h3);
    end
    ci = 0; k = 0; cyc = 0; stalled = 1'b0; bubble_chk = 1'b0; prev = '0;
    while (k < 10 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      beat_ready = 1'($urandom_range(0, 1));
      if (ci < 3) begin
        cmd_valid = 1'b1;
        cmd_burst = cb[ci]; cmd_addr = ca[ci]; cmd_len = cl[ci]; cmd_size = cs[ci];
        cmd_id = cid[ci];
      end else begin
        cmd_valid = 1'b0;
      end
      #1;
      if (stalled) check("b2b_stable", beat_vec(), prev);
      if (bubble_chk) check("b2b_beat0_next_cycle", {beat_valid, beat_index}, {1'b1, 8'd0});
      bh = beat_valid && beat_ready;
      ch = cmd_valid && cmd_ready;
      if (bh) begin
        check($sformatf("b2b_beat%0d", k), {beat_id, beat_addr, beat_index, beat_last, beat_error},
              {beid[k], bea[k], bei[k], bel[k], 1'b0});
        k++;
      end
      if (ch && ci > 0) check("b2b_accept_on_last", bh && beat_last, 1);
      bubble_chk = ch;
      stalled    = beat_valid && !beat_ready;
      prev       = beat_vec();
      if (ch) ci++;
    end
    check("b2b_beat_count", k, 10);
    check("b2b_cmd_count", ci, 3);
    @(negedge clk);
    cmd_valid = 1'b0; beat_ready = 1'b0;
    #1;
    check("b2b_idle_after", beat_valid, 0);

    // Reset during beat 2 of a len=7 INCR
    issue_cmd(2'd1, 32'h100, 8'd7, 3'd3, 4'h5);
    step("rst_burst_b0", exp_vec(4'h5, 32'h100, 3'd0, 8'd0, 0, 0));
    step("rst_burst_b1", exp_vec(4'h5, 32'h108, 3'd0, 8'd1, 0, 0));
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_at_beat2", {beat_valid, beat_addr, beat_index}, {1'b1, 32'h110, 8'd2});
    check("rst_cmd_ready_low", cmd_ready, 0);
    @(negedge clk);
    #1;
    check("rst_outputs_zero", beat_vec(), 64'd0);
    rst = 1'b0;
    #1;
    check("rst_cmd_ready_high", cmd_ready, 1);
    issue_cmd(2'd1, 32'h300, 8'd1, 3'd2, 4'h6);
    step("post_rst_b0", exp_vec(4'h6, 32'h300, 3'd0, 8'd0, 0, 0));
    step("post_rst_b1", exp_vec(4'h6, 32'h304, 3'd4, 8'd1, 1, 0));
    @(negedge clk);
    #1;
    check("post_rst_idle", beat_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
